// File: rtl/i2c_bit_ctrl.sv
// i2c_bit_ctrl: bit-level I2C engine executing START/STOP/WRITE/READ primitives on 4x-SCL ticks.
module i2c_bit_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       arstn_i,
  input  logic       tick_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic       din_i,
  output logic       dout_valid_o,
  output logic       dout_o,
  output logic       arb_lost_o,
  output logic       busy_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o
);
  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3} state_t;
  state_t state, state_nxt;
  logic [1:0] cmd;
  logic din, smp, scl_s, sda_s, accept, adv, lost;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign cmd_ready_o = state == IDLE;
  // {scl_oe, sda_oe} for a given command and phase
  function automatic logic [1:0] drive(input logic [1:0] c, input logic d, input state_t s);
    drive = c == 2'b00 ? {s == P3, s == P2 || s == P3}
          : c == 2'b01 ? {s == P0, s != P3}
          : {s == P0 || s == P3, c == 2'b10 && !d};
  endfunction
  always_comb begin
    accept = cmd_valid_i && state == IDLE;
    adv = tick_i && state != IDLE && (state != P1 || scl_s);
    lost = adv && state == P2 && cmd == 2'b10 && din && !sda_s;
    state_nxt = accept ? P0
              : lost ? IDLE
              : adv ? (state == P3 ? IDLE : state_t'(state + 3'd1))
              : state;
  end
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state <= IDLE;
      cmd <= 2'b00;
      din <= 1'b0;
      smp <= 1'b0;
      scl_oe_o <= 1'b0;
      sda_oe_o <= 1'b0;
      dout_o <= 1'b0;
      dout_valid_o <= 1'b0;
      arb_lost_o <= 1'b0;
      busy_o <= 1'b0;
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      state <= state_nxt;
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      dout_valid_o <= adv && state == P3 && cmd[1];
      arb_lost_o <= lost;
      if (accept) begin
        cmd <= cmd_i;
        din <= din_i;
        {scl_oe_o, sda_oe_o} <= drive(cmd_i, din_i, P0);
      end else if (lost) begin
        {scl_oe_o, sda_oe_o} <= 2'b00;
      end else if (adv && state != P3) begin
        {scl_oe_o, sda_oe_o} <= drive(cmd, din, state_nxt);
      end
      if (adv && state == P2) smp <= sda_s;
      if (adv && state == P3 && cmd[1]) dout_o <= smp;
      if (lost) busy_o <= 1'b0;
      else if (adv && state == P3 && cmd == 2'b00) busy_o <= 1'b1;
      else if (adv && state == P3 && cmd == 2'b01) busy_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// tb_i2c_bit_ctrl: directed stimulus with a queue scoreboard for dout_valid/arb_lost events.
module tb_i2c_bit_ctrl;
  logic clk = 0, arstn = 0, tick = 0, cmd_valid = 0, din = 0;
  logic [1:0] cmd = 2'b00;
  logic cmd_ready, dout_valid, dout, arb_lost, busy, scl_oe, sda_oe;
  logic stretch = 0, sda_force = 0, sda_val = 0;
  logic scl, sda;
  int errors = 0, checks = 0, pops = 0, pushes = 0;
  typedef struct {logic arb; logic d;} exp_t;
  exp_t q[$];

  assign scl = !scl_oe && !stretch;
  assign sda = sda_force ? sda_val : !sda_oe;

  i2c_bit_ctrl #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .arstn_i(arstn), .tick_i(tick), .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready), .cmd_i(cmd), .din_i(din), .dout_valid_o(dout_valid),
    .dout_o(dout), .arb_lost_o(arb_lost), .busy_o(busy), .scl_i(scl), .sda_i(sda),
    .scl_oe_o(scl_oe), .sda_oe_o(sda_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic d);
    exp_t e;
    e.arb = kind == 1;
    e.d = d;
    if (kind >= 0) begin
      q.push_back(e);
      pushes++;
    end
  endtask

  always @(negedge clk) begin
    if (arstn && (dout_valid || arb_lost)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: valid=%b arb=%b expected none at %0t", dout_valid, arb_lost, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        pops++;
        check("ev_arb", {7'd0, arb_lost}, {7'd0, e.arb});
        check("ev_valid", {7'd0, dout_valid}, {7'd0, !e.arb});
        if (!e.arb) check("ev_dout", {7'd0, dout}, {7'd0, e.d});
      end
    end
  end

  task automatic tick4();
    repeat (3) @(negedge clk);
    tick = 1;
    @(negedge clk);
    tick = 0;
  endtask

  task automatic send(input logic [1:0] c, input logic d, input int kind, input logic ed);
    int n = 0;
    @(negedge clk);
    cmd = c;
    din = d;
    cmd_valid = 1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {7'd0, cmd_ready}, 8'd1);
    push(kind, ed);
    @(negedge clk);
    cmd_valid = 0;
    check("ready_drop", {7'd0, cmd_ready}, 8'd0);
  endtask

  // drv packs expected {scl_oe,sda_oe} for P0..P3, P0 in the top bits
  task automatic run(input string nm, input logic [1:0] c, input logic d, input int kind,
                     input logic ed, input logic [7:0] drv);
    send(c, d, kind, ed);
    check({nm, "_p0"}, {6'd0, scl_oe, sda_oe}, {6'd0, drv[7:6]});
    for (int i = 1; i < 4; i++) begin
      tick4();
      check($sformatf("%s_p%0d", nm, i), {6'd0, scl_oe, sda_oe}, {6'd0, drv[7-2*i -: 2]});
    end
    check({nm, "_busy_cmd"}, {7'd0, cmd_ready}, 8'd0);
    tick4();
    check({nm, "_done_ready"}, {7'd0, cmd_ready}, 8'd1);
    check({nm, "_hold"}, {6'd0, scl_oe, sda_oe}, {6'd0, drv[1:0]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    repeat (3) @(negedge clk);
    arstn = 1;
    @(negedge clk);
    check("rst_ready", {7'd0, cmd_ready}, 8'd1);
    check("rst_drv", {6'd0, scl_oe, sda_oe}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_dout", {7'd0, dout}, 8'd0);
    run("start", 2'b00, 1'b0, -1, 1'b0, 8'b00_00_01_11);
    check("start_busy", {7'd0, busy}, 8'd1);
    run("wr0", 2'b10, 1'b0, 0, 1'b0, 8'b11_01_01_11);
    sda_force = 1;
    sda_val = 1;
    run("rd1", 2'b11, 1'b0, 0, 1'b1, 8'b10_00_00_10);
    sda_force = 0;
    run("stop", 2'b01, 1'b0, -1, 1'b0, 8'b11_01_01_00);
    check("stop_busy", {7'd0, busy}, 8'd0);
    // arbitration loss on a driven-high data bit
    run("start2", 2'b00, 1'b0, -1, 1'b0, 8'b00_00_01_11);
    sda_force = 1;
    sda_val = 0;
    send(2'b10, 1'b1, 1, 1'b0);
    tick4();
    tick4();
    check("arb_p2_ready", {7'd0, cmd_ready}, 8'd0);
    tick4();
    check("arb_drv", {6'd0, scl_oe, sda_oe}, 8'd0);
    check("arb_ready", {7'd0, cmd_ready}, 8'd1);
    check("arb_busy", {7'd0, busy}, 8'd0);
    tick4();
    check("arb_idle", {7'd0, cmd_ready}, 8'd1);
    // clock stretching during P1 of a READ
    stretch = 1;
    send(2'b11, 1'b0, 0, 1'b0);
    repeat (11) tick4();
    check("stretch_hold", {7'd0, cmd_ready}, 8'd0);
    check("stretch_drv", {6'd0, scl_oe, sda_oe}, 8'd0);
    stretch = 0;
    tick4();
    tick4();
    check("stretch_p3", {7'd0, cmd_ready}, 8'd0);
    tick4();
    check("stretch_done", {7'd0, cmd_ready}, 8'd1);
    sda_force = 0;
    // backpressure: valid held across three commands
    accepted = 0;
    fork
      begin
        logic [1:0] cs[3] = '{2'b10, 2'b10, 2'b11};
        logic ds[3] = '{1'b1, 1'b0, 1'b0};
        logic es[3] = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
          int n = 0;
          @(negedge clk);
          cmd = cs[k];
          din = ds[k];
          cmd_valid = 1;
          while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
          end
          if (cmd_ready) begin
            push(0, es[k]);
            accepted++;
          end
        end
        @(negedge clk);
        cmd_valid = 0;
      end
      begin
        repeat (14) tick4();
      end
    join
    check("bp_accepted", 8'(accepted), 8'd3);
    // asynchronous reset during WRITE P2
    send(2'b10, 1'b0, -1, 1'b0);
    tick4();
    tick4();
    check("mid_p2_drv", {6'd0, scl_oe, sda_oe}, 8'b01);
    #1 arstn = 0;
    #1;
    check("arst_drv", {6'd0, scl_oe, sda_oe}, 8'd0);
    check("arst_ready", {7'd0, cmd_ready}, 8'd1);
    check("arst_dout", {7'd0, dout}, 8'd0);
    check("arst_busy", {7'd0, busy}, 8'd0);
    tick4();
    @(negedge clk);
    arstn = 1;
    tick4();
    check("post_rst_ready", {7'd0, cmd_ready}, 8'd1);
    check("queue_empty", 8'(q.size()), 8'd0);
    check("event_count", 8'(pops), 8'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
